// File: rtl/latch_write_pkg.sv
// Shared types and sizing helpers for the latch-safe write sequencer.
package latch_write_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StEnable = 3'd2,
    StHold   = 3'd3,
    StCheck  = 3'd4
  } lw_state_e;

  localparam int unsigned DefaultWidth = 4;

  // Wide enough to hold the longest phase length.
  function automatic int unsigned cnt_width(input int unsigned setup_cycles,
                                            input int unsigned en_cycles,
                                            input int unsigned hold_cycles);
    int unsigned longest;
    longest = setup_cycles;
    if (en_cycles > longest) longest = en_cycles;
    if (hold_cycles > longest) longest = hold_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/latch_phase_timer.sv
// Loadable down-counter; last is high while the current phase is in its final cycle.
module latch_phase_timer #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            last
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CntW'(1));

endmodule

// File: rtl/latch_write_seq.sv
// Converts a valid/ready write into a setup / enable / hold sequence toward a
// level-sensitive storage element, then checks the element's readback.
module latch_write_seq
  import latch_write_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned EN_CYCLES    = 2,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_en,
  output logic [WIDTH-1:0] o_a,
  input  logic [WIDTH-1:0] i_rb,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned CntW = cnt_width(SETUP_CYCLES, EN_CYCLES, HOLD_CYCLES);

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYCLES);
  localparam logic [CntW-1:0] EnLd    = CntW'(EN_CYCLES);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYCLES);

  lw_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             en_q, ready_q, busy_q, done_q, err_q;
  logic             accept;
  logic             load;
  logic [CntW-1:0]  load_val;
  logic             last;
  logic             rb_match;

  latch_phase_timer #(
    .CntW(CntW)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (load),
    .load_val(load_val),
    .last    (last)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (i_valid && ready_q) begin
          accept   = 1'b1;
          load     = 1'b1;
          load_val = SetupLd;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (last) begin
          load     = 1'b1;
          load_val = EnLd;
          state_d  = StEnable;
        end
      end
      StEnable: begin
        if (last) begin
          load     = 1'b1;
          load_val = HoldLd;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (last) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Readback only matters in CHECK; gating keeps X on i_rb elsewhere out of the flops.
  assign rb_match = (state_q == StCheck) && (i_rb == data_q);

  // Outputs are registered from the next state so o_en is glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= i_data;
      end
      en_q    <= (state_d == StEnable);
      ready_q <= (state_d == StIdle);
      busy_q  <= (state_d != StIdle);
      done_q  <= rb_match;
      err_q   <= (state_q == StCheck) && !rb_match;
    end
  end

  assign o_en    = en_q;
  assign o_a     = data_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_latch_write_seq.sv
// Directed bench for latch_write_seq with a level-sensitive storage model on the readback.
module tb_latch_write_seq;

  localparam int W  = 4;
  // Default instance: edges after the accept edge at which o_en is set / done pulses.
  localparam int S  = 1;
  localparam int E  = 2;
  localparam int L  = 5;
  // Swept instance: SETUP=3, EN=1, HOLD=2.
  localparam int S2 = 3;
  localparam int E2 = 1;
  localparam int L2 = 7;

  logic         clk;
  logic         rst_n;
  logic         valid, ready, en, busy, done, err, fault_rb;
  logic [W-1:0] data, a, rb, lat_q;
  logic         valid2, ready2, en2, busy2, done2, err2;
  logic [W-1:0] data2, a2, rb2, lat2_q;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [W-1:0] data;
    logic         fault;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t vecs[5];

  latch_write_seq dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .o_ready(ready),
    .i_data (data),
    .o_en   (en),
    .o_a    (a),
    .i_rb   (rb),
    .o_busy (busy),
    .o_done (done),
    .o_err  (err)
  );

  latch_write_seq #(
    .WIDTH       (W),
    .SETUP_CYCLES(3),
    .EN_CYCLES   (1),
    .HOLD_CYCLES (2)
  ) dut2 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid2),
    .o_ready(ready2),
    .i_data (data2),
    .o_en   (en2),
    .o_a    (a2),
    .i_rb   (rb2),
    .o_busy (busy2),
    .o_done (done2),
    .o_err  (err2)
  );

  // Storage element models: transparent while enable is high.
  always_latch if (en) lat_q <= a;
  always_latch if (en2) lat2_q <= a2;

  assign rb  = fault_rb ? '0 : lat_q;
  assign rb2 = lat2_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ready"}, 32'(ready), 32'd1);
    check({tag, " en"}, 32'(en), 32'd0);
    check({tag, " a"}, 32'(a), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  // One write on the default instance; samples at each negedge after the k-th edge
  // following the accept edge (k = 0 is the cycle right after accept).
  task automatic run_write(input logic [W-1:0] d, input logic fault,
                           input logic exp_done, input logic exp_err);
    @(negedge clk);
    check($sformatf("pre ready d%0h", d), 32'(ready), 32'd1);
    valid = 1'b1;
    data  = d;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      check($sformatf("a d%0h k%0d", d, k), 32'(a), 32'(d));
      check($sformatf("en d%0h k%0d", d, k), 32'(en), 32'((k >= S && k < S + E) ? 1 : 0));
      check($sformatf("busy d%0h k%0d", d, k), 32'(busy), 32'((k < L) ? 1 : 0));
      check($sformatf("ready d%0h k%0d", d, k), 32'(ready), 32'((k < L) ? 0 : 1));
      check($sformatf("done d%0h k%0d", d, k), 32'(done), 32'((k == L) ? exp_done : 1'b0));
      check($sformatf("err d%0h k%0d", d, k), 32'(err), 32'((k == L) ? exp_err : 1'b0));
      if (k == L) check($sformatf("latched d%0h", d), 32'(lat_q), 32'(d));
      // CHECK occupies the cycle after edge L-1.
      fault_rb = fault && (k == L - 1);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    data     = '0;
    fault_rb = 1'b0;
    valid2   = 1'b0;
    data2    = '0;

    vecs[0] = '{data: 4'hA, fault: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 4'h5, fault: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{data: 4'hF, fault: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 4'h0, fault: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 4'h3, fault: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

    repeat (2) @(negedge clk);
    check_reset("reset");
    check("reset ready2", 32'(ready2), 32'd1);
    check("reset en2", 32'(en2), 32'd0);
    check("reset a2", 32'(a2), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_write(vecs[i].data, vecs[i].fault, vecs[i].exp_done, vecs[i].exp_err);

    // Back-pressure: valid held high, data changing every cycle.
    @(negedge clk);
    valid = 1'b1;
    data  = 4'h1;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      check($sformatf("bp a k%0d", k), 32'(a), 32'h1);
      check($sformatf("bp ready k%0d", k), 32'(ready), 32'((k == L) ? 1 : 0));
      data = 4'(k + 2);
    end
    // Second accept happens on the edge after ready returns, capturing 7.
    @(negedge clk);
    valid = 1'b0;
    check("bp second a", 32'(a), 32'h7);
    check("bp second busy", 32'(busy), 32'd1);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      check($sformatf("bp2 en k%0d", k), 32'(en), 32'((k >= S && k < S + E) ? 1 : 0));
      check($sformatf("bp2 a k%0d", k), 32'(a), 32'h7);
      check($sformatf("bp2 done k%0d", k), 32'(done), 32'((k == L) ? 1 : 0));
    end
    check("bp2 latched", 32'(lat_q), 32'h7);

    // Parameter sweep on the second instance.
    @(negedge clk);
    valid2 = 1'b1;
    data2  = 4'hF;
    for (int k = 0; k <= L2; k++) begin
      @(negedge clk);
      if (k == 0) valid2 = 1'b0;
      check($sformatf("sw a k%0d", k), 32'(a2), 32'hF);
      check($sformatf("sw en k%0d", k), 32'(en2), 32'((k >= S2 && k < S2 + E2) ? 1 : 0));
      check($sformatf("sw busy k%0d", k), 32'(busy2), 32'((k < L2) ? 1 : 0));
      check($sformatf("sw done k%0d", k), 32'(done2), 32'((k == L2) ? 1 : 0));
      check($sformatf("sw err k%0d", k), 32'(err2), 32'd0);
    end
    check("sw latched", 32'(lat2_q), 32'hF);

    // Asynchronous reset while o_en is high.
    @(negedge clk);
    valid = 1'b1;
    data  = 4'h9;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("arst en before", 32'(en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("arst now");
    repeat (3) begin
      @(negedge clk);
      check_reset("arst held");
    end
    rst_n = 1'b1;
    for (int k = 0; k < L + 2; k++) begin
      @(negedge clk);
      check($sformatf("arst post done k%0d", k), 32'(done), 32'd0);
      check($sformatf("arst post err k%0d", k), 32'(err), 32'd0);
      check($sformatf("arst post busy k%0d", k), 32'(busy), 32'd0);
    end
    run_write(4'h6, 1'b0, 1'b1, 1'b0);

    // Idle stability after the last write.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("idle en k%0d", k), 32'(en), 32'd0);
      check($sformatf("idle a k%0d", k), 32'(a), 32'h6);
      check($sformatf("idle rb k%0d", k), 32'(rb), 32'h6);
      check($sformatf("idle ready k%0d", k), 32'(ready), 32'd1);
      check($sformatf("idle done k%0d", k), 32'(done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
